mem_wb_stage_buf: RTL and testbench

//  Parametrised, elastic MEM->WB pipeline stage: a 2-entry skid buffer with valid/ready handshake on both sides.

---
 rtl/mem_wb_stage_buf.sv | 122 ++++++++++++
 tb/tb_mem_wb_stage_buf.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_buf.sv
// Elastic MEM->WB pipeline stage: two-entry skid buffer (head + skid) with valid/ready
// on both sides, control squashed on bubbles/flush, and sticky halt retirement tracking.
module mem_wb_stage_buf #(
   parameter int CTRL_W  = 4,
   parameter int DATA_W  = 52,
   parameter int HLT_BIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic              hlt_done
);

   logic              hValid_q, hValid_d;
   logic [CTRL_W-1:0] hCtrl_q,  hCtrl_d;
   logic [DATA_W-1:0] hData_q,  hData_d;
   logic              sValid_q, sValid_d;
   logic [CTRL_W-1:0] sCtrl_q,  sCtrl_d;
   logic [DATA_W-1:0] sData_q,  sData_d;
   logic [1:0]        occ_q,    occ_d;
   logic              haltLatched_q, haltLatched_d;
   logic              hltDone_q,     hltDone_d;
   logic              accept, pop, popHalt;

   assign in_ready  = ~sValid_q & ~haltLatched_q & ~flush;
   assign accept    = in_valid & in_ready;
   assign pop       = hValid_q & out_ready;
   assign popHalt   = pop & hCtrl_q[HLT_BIT];

   assign out_valid = hValid_q;
   assign out_ctrl  = hCtrl_q;
   assign out_data  = hData_q;
   assign occupancy = occ_q;
   assign hlt_done  = hltDone_q;

   // Head/skid update; ctrl registers are cleared whenever their entry becomes empty
   always_comb begin
      hValid_d = hValid_q;
      hCtrl_d  = hCtrl_q;
      hData_d  = hData_q;
      sValid_d = sValid_q;
      sCtrl_d  = sCtrl_q;
      sData_d  = sData_q;
      if (flush) begin
         hValid_d = 1'b0;
         hCtrl_d  = '0;
         sValid_d = 1'b0;
         sCtrl_d  = '0;
      end else if (!hValid_q) begin
         if (accept) begin
            hValid_d = 1'b1;
            hCtrl_d  = in_ctrl;
            hData_d  = in_data;
         end
      end else if (pop) begin
         if (sValid_q) begin
            hCtrl_d  = sCtrl_q;
            hData_d  = sData_q;
            sValid_d = 1'b0;
            sCtrl_d  = '0;
         end else if (accept) begin
            hCtrl_d  = in_ctrl;
            hData_d  = in_data;
         end else begin
            hValid_d = 1'b0;
            hCtrl_d  = '0;
         end
      end else if (accept) begin
         sValid_d = 1'b1;
         sCtrl_d  = in_ctrl;
         sData_d  = in_data;
      end
      occ_d = {1'b0, hValid_d} + {1'b0, sValid_d};
   end

   // A halt retiring in the same cycle as a flush is architectural, so it keeps the latch
   always_comb begin
      haltLatched_d = haltLatched_q;
      hltDone_d     = hltDone_q | popHalt;
      if (flush) begin
         if (!hltDone_q && !popHalt) begin
            haltLatched_d = 1'b0;
         end
      end else if (accept && in_ctrl[HLT_BIT]) begin
         haltLatched_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hValid_q      <= 1'b0;
         hCtrl_q       <= '0;
         hData_q       <= '0;
         sValid_q      <= 1'b0;
         sCtrl_q       <= '0;
         sData_q       <= '0;
         occ_q         <= 2'd0;
         haltLatched_q <= 1'b0;
         hltDone_q     <= 1'b0;
      end else begin
         hValid_q      <= hValid_d;
         hCtrl_q       <= hCtrl_d;
         hData_q       <= hData_d;
         sValid_q      <= sValid_d;
         sCtrl_q       <= sCtrl_d;
         sData_q       <= sData_d;
         occ_q         <= occ_d;
         haltLatched_q <= haltLatched_d;
         hltDone_q     <= hltDone_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Self-checking bench for mem_wb_stage_buf: directed scenarios plus random traffic,
// all compared against a queue-based model of the stage.
module tb_mem_wb_stage_buf;

   localparam int CTRL_W = 4;
   localparam int DATA_W = 52;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic              hlt_done;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t fifo[$];
   bit     mHalt = 1'b0;
   bit     mDone = 1'b0;
   int     errors = 0;
   int     checks = 0;

   mem_wb_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .HLT_BIT(0)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .hlt_done(hlt_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkState();
      checkOutput("out_valid", 64'(out_valid), 64'(fifo.size() > 0));
      checkOutput("out_ctrl", 64'(out_ctrl), (fifo.size() > 0) ? 64'(fifo[0].ctrl) : 64'd0);
      if (fifo.size() > 0) checkOutput("out_data", 64'(out_data), 64'(fifo[0].data));
      checkOutput("occupancy", 64'(occupancy), 64'(fifo.size()));
      checkOutput("hlt_done", 64'(hlt_done), 64'(mDone));
   endtask

   // Called just after a falling edge; drives one cycle and checks the registered result
   task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                                input logic [DATA_W-1:0] d, input logic r, input logic f);
      bit expReady, acc, pp, popHlt;
      in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
      #1;
      expReady = (fifo.size() < 2) && !mHalt && !f;
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      acc = v && expReady;
      pp  = (fifo.size() > 0) && r;
      @(posedge clk);
      popHlt = 1'b0;
      if (pp) begin
         popHlt = fifo[0].ctrl[0];
         void'(fifo.pop_front());
      end
      if (f) begin
         fifo.delete();
         if (!mDone && !popHlt) mHalt = 1'b0;
      end else if (acc) begin
         fifo.push_back(entry_t'{ctrl: c, data: d});
         if (c[0]) mHalt = 1'b1;
      end
      if (popHlt) mDone = 1'b1;
      @(negedge clk);
      checkState();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop immediately
   task automatic doReset();
      #2;
      rst = 1'b0;
      in_valid = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
      in_ctrl = 4'($urandom); in_data = {20'($urandom), 32'($urandom)};
      #1;
      checkOutput("rst out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst out_ctrl", 64'(out_ctrl), 64'd0);
      checkOutput("rst out_data", 64'(out_data), 64'd0);
      checkOutput("rst occupancy", 64'(occupancy), 64'd0);
      checkOutput("rst hlt_done", 64'(hlt_done), 64'd0);
      fifo.delete();
      mHalt = 1'b0;
      mDone = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      logic [CTRL_W-1:0] rc;
      @(negedge clk);
      doReset();

      $display("[TB] stream");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b0100, 52'(i), 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 52'd0, 1'b1, 1'b0);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 4'b0100, 52'hA, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'hB, 1'b0, 1'b0);
      checkOutput("bp occupancy", 64'(occupancy), 64'd2);
      applyStimulus(1'b1, 4'b0100, 52'hC, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 52'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 52'd0, 1'b1, 1'b0);

      $display("[TB] flush");
      applyStimulus(1'b1, 4'b0100, 52'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h22, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h33, 1'b0, 1'b1);
      checkOutput("flush occupancy", 64'(occupancy), 64'd0);
      checkOutput("flush out_ctrl", 64'(out_ctrl), 64'd0);

      $display("[TB] halt");
      applyStimulus(1'b1, 4'b0100, 52'h100, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0001, 52'h200, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h300, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h300, 1'b1, 1'b1);
      checkOutput("halt sticky", 64'(hlt_done), 64'd1);
      applyStimulus(1'b1, 4'b0100, 52'h400, 1'b1, 1'b0);
      @(negedge clk);
      doReset();

      $display("[TB] speculative halt");
      applyStimulus(1'b1, 4'b0001, 52'h500, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 52'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b0100, 52'h600, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h700, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 52'h800, 1'b0, 1'b0);
      doReset();

      $display("[TB] random");
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 249) begin
            @(negedge clk);
            doReset();
         end
         rd = {20'($urandom), 32'($urandom)};
         rc = {3'($urandom), 1'($urandom_range(29) == 0)};
         applyStimulus(1'($urandom_range(3) != 0), rc, rd,
                       1'($urandom_range(2) != 0), 1'($urandom_range(24) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
